regfile_wb_sequencer: RTL



---
 rtl/regfile_wb_sequencer.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/regfile_wb_sequencer.sv
// regfile_wb_sequencer
// Write-back sequencer for the Y86 SEQ register file, which has one write port.
// Each accepted request (dstE/valE, dstM/valM) becomes at most two single-port
// writes: the E write first, then the M write. A pending-write scoreboard
// (pend_mask) lets decode stall when srcA/srcB name a register whose write has
// not yet been committed.
module regfile_wb_sequencer #(
  parameter int DATA_W = 64,
  parameter int NREG   = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [3:0]        dstE,
  input  logic [DATA_W-1:0] valE,
  input  logic [3:0]        dstM,
  input  logic [DATA_W-1:0] valM,
  input  logic [3:0]        srcA,
  input  logic [3:0]        srcB,
  output logic              rf_we,
  output logic [3:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [NREG-1:0]   pend_mask,
  output logic              hazard,
  output logic              busy
);

  // Register id meaning "no register".
  localparam logic [3:0] ID_NONE = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR_E = 2'd1,
    WR_M = 2'd2
  } state_t;

  // Any id outside the architectural range is treated as "no register".
  function automatic logic [3:0] norm_id(input logic [3:0] id);
    logic [3:0] r;
    if (id < 4'(NREG)) begin
      r = id;
    end else begin
      r = ID_NONE;
    end
    return r;
  endfunction

  // One-hot scoreboard bit for a register id; no bit for ids outside the range.
  function automatic logic [NREG-1:0] id_mask(input logic [3:0] id);
    logic [NREG-1:0] m;
    m = '0;
    for (int i = 0; i < NREG; i++) begin
      m[i] = (id == 4'(i));
    end
    return m;
  endfunction

  // True when the id names a register that has a pending write.
  function automatic logic id_hit(input logic [NREG-1:0] mask, input logic [3:0] id);
    return |(mask & id_mask(id));
  endfunction

  // State and latched request fields. dste_r holds the *effective* E id:
  // it is ID_NONE whenever the E write is dropped.
  state_t            state_r;
  logic [3:0]        dste_r;
  logic [3:0]        dstm_r;
  logic [DATA_W-1:0] vale_r;
  logic [DATA_W-1:0] valm_r;
  logic [NREG-1:0]   pend_r;
  logic              rf_we_r;
  logic [3:0]        rf_waddr_r;
  logic [DATA_W-1:0] rf_wdata_r;

  // Next-state values.
  state_t            state_s;
  logic [3:0]        dste_s;
  logic [3:0]        dstm_s;
  logic [DATA_W-1:0] vale_s;
  logic [DATA_W-1:0] valm_s;
  logic [NREG-1:0]   pend_s;
  logic              rf_we_s;
  logic [3:0]        rf_waddr_s;
  logic [DATA_W-1:0] rf_wdata_s;

  // Incoming request decode.
  logic       accept_s;
  logic [3:0] in_dste_s;
  logic [3:0] in_dstm_s;
  logic       in_ee_s;
  logic       in_em_s;

  assign wb_ready  = (state_r == IDLE);
  assign busy      = (state_r != IDLE);
  assign accept_s  = wb_valid & wb_ready;
  assign in_dstm_s = norm_id(dstM);
  assign in_em_s   = (in_dstm_s != ID_NONE);
  // When both ids name the same register the M value wins, so E is dropped.
  assign in_ee_s   = (norm_id(dstE) != ID_NONE) && (norm_id(dstE) != in_dstm_s);
  assign in_dste_s = in_ee_s ? norm_id(dstE) : ID_NONE;

  // Next state, latched fields and scoreboard update.
  always_comb begin
    state_s = state_r;
    dste_s  = dste_r;
    dstm_s  = dstm_r;
    vale_s  = vale_r;
    valm_s  = valm_r;
    pend_s  = pend_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          dste_s = in_dste_s;
          dstm_s = in_dstm_s;
          vale_s = valE;
          valm_s = valM;
          pend_s = pend_r | id_mask(in_dste_s) | id_mask(in_dstm_s);
          if (in_ee_s) begin
            state_s = WR_E;
          end else if (in_em_s) begin
            state_s = WR_M;
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      WR_E: begin
        // E write commits on this edge.
        pend_s = pend_r & ~id_mask(dste_r);
        if (dstm_r != ID_NONE) begin
          state_s = WR_M;
        end else begin
          state_s = IDLE;
        end
      end
      WR_M: begin
        // M write commits on this edge.
        pend_s  = pend_r & ~id_mask(dstm_r);
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
        pend_s  = '0;
      end
    endcase
  end

  // Register-file port values for the coming cycle, derived from the next state
  // so the write is presented in the same cycle the state is entered.
  always_comb begin
    rf_we_s    = 1'b0;
    rf_waddr_s = ID_NONE;
    rf_wdata_s = rf_wdata_r;
    case (state_s)
      WR_E: begin
        rf_we_s    = 1'b1;
        rf_waddr_s = dste_s;
        rf_wdata_s = vale_s;
      end
      WR_M: begin
        rf_we_s    = 1'b1;
        rf_waddr_s = dstm_s;
        rf_wdata_s = valm_s;
      end
      IDLE: begin
        rf_we_s    = 1'b0;
        rf_waddr_s = ID_NONE;
        rf_wdata_s = rf_wdata_r;
      end
      default: begin
        rf_we_s    = 1'b0;
        rf_waddr_s = ID_NONE;
        rf_wdata_s = rf_wdata_r;
      end
    endcase
  end

  // Sequencer state, latched request and registered outputs; reset discards
  // any outstanding writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      dste_r     <= ID_NONE;
      dstm_r     <= ID_NONE;
      vale_r     <= '0;
      valm_r     <= '0;
      pend_r     <= '0;
      rf_we_r    <= 1'b0;
      rf_waddr_r <= ID_NONE;
      rf_wdata_r <= '0;
    end else begin
      state_r    <= state_s;
      dste_r     <= dste_s;
      dstm_r     <= dstm_s;
      vale_r     <= vale_s;
      valm_r     <= valm_s;
      pend_r     <= pend_s;
      rf_we_r    <= rf_we_s;
      rf_waddr_r <= rf_waddr_s;
      rf_wdata_r <= rf_wdata_s;
    end
  end

  assign rf_we     = rf_we_r;
  assign rf_waddr  = rf_waddr_r;
  assign rf_wdata  = rf_wdata_r;
  assign pend_mask = pend_r;

  // Decode hazard: a source id names a register with a write still pending.
  assign hazard = id_hit(pend_r, srcA) | id_hit(pend_r, srcB);

endmodule
